// File: rtl/e_mdu_pkg.sv
// Shared op codes, latency defaults and op-class helpers for the E-stage multiply/divide unit.
// MDU_MADD_EN enables the madd/msub op class in mul_class().
package e_mdu_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MADD  = 4'd7,
    OP_MADDU = 4'd8,
    OP_MSUB  = 4'd9,
    OP_MSUBU = 4'd10
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

  function automatic logic mul_class(input logic [3:0] op);
    logic r;
    r = (op == OP_MULT) || (op == OP_MULTU);
`ifdef MDU_MADD_EN
    r = r || (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
`endif
    return r;
  endfunction

  function automatic logic div_class(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/e_mdu_calc.sv
// Combinational mult/div datapath: {op, rs, rt, HI, LO} -> 64-bit {tHI, tLO}, zero cycles.
// Divide by zero returns the current {HI, LO}; MDU_MADD_EN adds accumulate/subtract forms.
module mdu_calc
  import e_mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] res
);

  logic [63:0]        prod_s;
  logic [63:0]        prod_u;
  logic signed [31:0] quo_s;
  logic signed [31:0] rem_s;
  logic [31:0]        quo_u;
  logic [31:0]        rem_u;
  logic               div_zero;

  // Low 64 bits of the product of sign-extended operands are the signed product.
  assign prod_s = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
  assign prod_u = {32'd0, rs} * {32'd0, rt};

  assign div_zero = (rt == 32'd0);
  assign quo_s    = div_zero ? 32'sd0 : $signed(rs) / $signed(rt);
  assign rem_s    = div_zero ? 32'sd0 : $signed(rs) % $signed(rt);
  assign quo_u    = div_zero ? 32'd0  : rs / rt;
  assign rem_u    = div_zero ? 32'd0  : rs % rt;

  always_comb begin
    res = {hi, lo};
    case (op)
      OP_MULT:  res = prod_s;
      OP_MULTU: res = prod_u;
      OP_DIV:   if (!div_zero) res = {rem_s, quo_s};
      OP_DIVU:  if (!div_zero) res = {rem_u, quo_u};
`ifdef MDU_MADD_EN
      OP_MADD:  res = {hi, lo} + prod_s;
      OP_MADDU: res = {hi, lo} + prod_u;
      OP_MSUB:  res = {hi, lo} - prod_s;
      OP_MSUBU: res = {hi, lo} - prod_u;
`endif
      default:  res = {hi, lo};
    endcase
  end

endmodule

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: mult-class ops commit HI/LO MULT_CYCLES after accept, div DIV_CYCLES, mthi/mtlo next cycle.
// Accepts only when start && !Req && !busy; anything else is dropped. MDU_MADD_EN enables madd/msub.
module e_mdu
  import e_mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Req,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned CNT_W = cnt_width(MULT_CYCLES, DIV_CYCLES);

  md_state_e          st_q, st_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [63:0]        tmp_q, tmp_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;
  logic [63:0]        calc_res;
  logic               accept;

  mdu_calc u_calc (
    .op  (op),
    .rs  (rs),
    .rt  (rt),
    .hi  (hi_q),
    .lo  (lo_q),
    .res (calc_res)
  );

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    tmp_d  = tmp_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    accept = start && !Req && (st_q == ST_IDLE);
    case (st_q)
      ST_RUN: begin
        // Req during RUN is deliberately ignored: an accepted op always commits.
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          st_d = ST_IDLE;
          hi_d = tmp_q[63:32];
          lo_d = tmp_q[31:0];
        end
      end
      default: begin
        if (accept) begin
          if (mul_class(op)) begin
            tmp_d = calc_res;
            cnt_d = CNT_W'(MULT_CYCLES);
            st_d  = ST_RUN;
          end else if (div_class(op)) begin
            tmp_d = calc_res;
            cnt_d = CNT_W'(DIV_CYCLES);
            st_d  = ST_RUN;
          end else if (op == OP_MTHI) begin
            hi_d = rs;
          end else if (op == OP_MTLO) begin
            lo_d = rs;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q  <= ST_IDLE;
      cnt_q <= '0;
      tmp_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      tmp_q <= tmp_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end

  assign busy = (st_q == ST_RUN);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule
